// File: rtl/chimp_board_engine_if.sv
// Front-end / renderer bundle for the chimp board engine.
// The master side drives start, PRNG and click inputs.
// The slave side (the engine) returns board, level and status.
interface chimp_board_engine_if #(
   parameter int ROWS   = 3,
   parameter int COLS   = 3,
   parameter int NUM_W  = 5,
   parameter int RAND_W = 8
);
   localparam int CELLS  = ROWS * COLS;
   localparam int CELL_W = NUM_W + 2;

   logic                      iStart;
   logic [RAND_W-1:0]         iRandNum;
   logic                      iClick;
   logic [2:0]                iBoxX;
   logic [2:0]                iBoxY;
   logic [CELLS*CELL_W-1:0]   oBoard;
   logic [NUM_W-1:0]          oLevel;
   logic [2:0]                oLives;
   logic [7:0]                oScore;
   logic                      oLevelDone;
   logic                      oGameOver;
   logic                      oWin;
   logic                      oBusy;

   modport master (
      output iStart, iRandNum, iClick, iBoxX, iBoxY,
      input  oBoard, oLevel, oLives, oScore, oLevelDone, oGameOver, oWin, oBusy
   );

   modport slave (
      input  iStart, iRandNum, iClick, iBoxX, iBoxY,
      output oBoard, oLevel, oLives, oScore, oLevelDone, oGameOver, oWin, oBusy
   );
endinterface

// File: rtl/chimp_board_engine.sv
// Chimp-test game engine for a ROWS x COLS board.
// Places 1..level in distinct random cells (linear probing on collision),
// scores in-order clicks, tracks lives and advances levels.
module chimp_board_engine #(
   parameter int ROWS        = 3,
   parameter int COLS        = 3,
   parameter int NUM_W       = 5,
   parameter int START_LEVEL = 4,
   parameter int LIVES       = 3,
   parameter int RAND_W      = 8
) (
   input logic                  clk,
   input logic                  iResetN,
   chimp_board_engine_if.slave  bus
);
   localparam int CELLS  = ROWS * COLS;
   localparam int CELL_W = NUM_W + 2;
   localparam int IDX_W  = $clog2(CELLS);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_SHOW, S_PLAY, S_DONE, S_OVER, S_WIN
   } state_t;

   state_t              state_q, state_d;
   logic [CELL_W-1:0]   board_q [CELLS];
   logic [CELL_W-1:0]   board_d [CELLS];
   logic [NUM_W-1:0]    level_q, level_d;
   logic [2:0]          lives_q, lives_d;
   logic [7:0]          score_q, score_d;
   logic [NUM_W-1:0]    k_q, k_d;
   logic [NUM_W-1:0]    exp_q, exp_d;
   logic [IDX_W-1:0]    probe_q, probe_d;
   logic                first_q, first_d;

   logic [RAND_W-1:0]   rand_mod;
   logic [IDX_W-1:0]    rand_idx;
   logic [IDX_W-1:0]    cand;
   logic [IDX_W-1:0]    click_idx;
   logic                click_in_range;
   logic [CELL_W-1:0]   click_cell;
   logic                click_hit;
   logic [CELLS*CELL_W-1:0] board_flat;

   // Click decode and first-probe candidate
   always_comb begin
      rand_mod       = bus.iRandNum % RAND_W'(CELLS);
      rand_idx       = IDX_W'(rand_mod);
      click_in_range = ({1'b0, bus.iBoxX} < 4'(COLS)) && ({1'b0, bus.iBoxY} < 4'(ROWS));
      click_idx      = IDX_W'(32'(bus.iBoxY) * COLS + 32'(bus.iBoxX));
      click_cell     = click_in_range ? board_q[click_idx] : '0;
      click_hit      = bus.iClick && click_in_range && click_cell[CELL_W-1];
   end

   // Next-state, board update and game bookkeeping
   always_comb begin
      state_d = state_q;
      board_d = board_q;
      level_d = level_q;
      lives_d = lives_q;
      score_d = score_q;
      k_d     = k_q;
      exp_d   = exp_q;
      probe_d = probe_q;
      first_d = first_q;
      cand    = first_q ? rand_idx : probe_q;

      if (bus.iStart) begin
         level_d = NUM_W'(START_LEVEL);
         lives_d = 3'(LIVES);
         score_d = '0;
         state_d = S_CLEAR;
      end else begin
         case (state_q)
            S_CLEAR: begin
               for (int unsigned i = 0; i < CELLS; i++) board_d[i] = '0;
               k_d     = NUM_W'(1);
               first_d = 1'b1;
               state_d = S_LOAD;
            end
            S_LOAD: begin
               if (!board_q[cand][CELL_W-1]) begin
                  board_d[cand] = {1'b1, 1'b1, k_q};
                  first_d       = 1'b1;
                  if (k_q == level_q) begin
                     exp_d   = NUM_W'(1);
                     state_d = S_SHOW;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end else begin
                  probe_d = (cand == IDX_W'(CELLS - 1)) ? '0 : cand + 1'b1;
                  first_d = 1'b0;
               end
            end
            S_SHOW, S_PLAY: begin
               if (click_hit) begin
                  if (click_cell[NUM_W-1:0] == exp_q) begin
                     board_d[click_idx] = '0;
                     exp_d              = exp_q + 1'b1;
                     if (exp_q == level_q) begin
                        state_d = S_DONE;
                     end else if (state_q == S_SHOW) begin
                        for (int unsigned i = 0; i < CELLS; i++) board_d[i][CELL_W-2] = 1'b0;
                        state_d = S_PLAY;
                     end
                  end else begin
                     lives_d = lives_q - 1'b1;
                     state_d = (lives_q == 3'd1) ? S_OVER : S_CLEAR;
                  end
               end
            end
            S_DONE: begin
               score_d = (score_q == 8'hFF) ? score_q : score_q + 1'b1;
               if (level_q == NUM_W'(CELLS)) begin
                  state_d = S_WIN;
               end else begin
                  level_d = level_q + 1'b1;
                  state_d = S_CLEAR;
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge iResetN) begin
      if (!iResetN) begin
         state_q <= S_IDLE;
         for (int unsigned i = 0; i < CELLS; i++) board_q[i] <= '0;
         level_q <= NUM_W'(START_LEVEL);
         lives_q <= 3'(LIVES);
         score_q <= '0;
         k_q     <= '0;
         exp_q   <= '0;
         probe_q <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         level_q <= level_d;
         lives_q <= lives_d;
         score_q <= score_d;
         k_q     <= k_d;
         exp_q   <= exp_d;
         probe_q <= probe_d;
         first_q <= first_d;
      end
   end

   // Flatten the board for the renderer
   always_comb begin
      board_flat = '0;
      for (int unsigned i = 0; i < CELLS; i++) board_flat[i*CELL_W +: CELL_W] = board_q[i];
   end

   assign bus.oBoard     = board_flat;
   assign bus.oLevel     = level_q;
   assign bus.oLives     = lives_q;
   assign bus.oScore     = score_q;
   assign bus.oLevelDone = (state_q == S_DONE);
   assign bus.oGameOver  = (state_q == S_OVER);
   assign bus.oWin       = (state_q == S_WIN);
   assign bus.oBusy      = (state_q == S_CLEAR) || (state_q == S_LOAD);
endmodule

// File: tb/tb_chimp_board_engine.sv
// Bench for chimp_board_engine on a 3x3 board: directed scenarios plus a
// randomized play phase checked against a game-level reference model.
module tb_chimp_board_engine;
   localparam int CELLS = 9;
   localparam int CW    = 7;
   localparam int PH_IDLE = 0, PH_SHOW = 1, PH_PLAY = 2, PH_OVER = 3, PH_WIN = 4, PH_BUSY = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chimp_board_engine_if #(.ROWS(3), .COLS(3), .NUM_W(5), .RAND_W(8)) bus ();
   chimp_board_engine_if #(.ROWS(3), .COLS(3), .NUM_W(5), .RAND_W(8)) bw ();

   chimp_board_engine #(.ROWS(3), .COLS(3), .NUM_W(5), .START_LEVEL(4), .LIVES(3), .RAND_W(8))
      dut (.clk(clk), .iResetN(rst_n), .bus(bus));
   chimp_board_engine #(.ROWS(3), .COLS(3), .NUM_W(5), .START_LEVEL(9), .LIVES(3), .RAND_W(8))
      dut_win (.clk(clk), .iResetN(rst_n), .bus(bw));

   int n_tests = 0;
   int n_fail  = 0;

   int m_num [CELLS];
   bit m_act [CELLS];
   bit m_shown [CELLS];
   int m_level, m_lives, m_score, m_exp, m_phase;
   int cur_r;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_board();
      logic [63:0] b;
      b = '0;
      for (int i = 0; i < CELLS; i++)
         if (m_act[i]) b[i*CW +: CW] = {1'b1, m_shown[i], 5'(m_num[i])};
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < CELLS; i++) begin m_num[i] = 0; m_act[i] = 0; m_shown[i] = 0; end
      m_level = 4; m_lives = 3; m_score = 0; m_exp = 0; m_phase = PH_IDLE;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".board"}, bus.oBoard, model_board());
      check({tag, ".level"}, bus.oLevel, m_level);
      check({tag, ".lives"}, bus.oLives, m_lives);
      check({tag, ".score"}, bus.oScore, m_score);
      check({tag, ".over"},  bus.oGameOver, m_phase == PH_OVER);
      check({tag, ".win"},   bus.oWin, m_phase == PH_WIN);
      check({tag, ".busy"},  bus.oBusy, m_phase == PH_BUSY);
   endtask

   task automatic set_rand();
      cur_r = $urandom_range(0, 255);
      bus.iRandNum = 8'(cur_r);
   endtask

   // Called right after the edge entering CLEAR; iRandNum = cur_r held throughout.
   task automatic do_load(input string tag);
      int c, cyc, cnt;
      for (int i = 0; i < CELLS; i++) begin m_num[i] = 0; m_act[i] = 0; m_shown[i] = 0; end
      cyc = 1;
      for (int k = 1; k <= m_level; k++) begin
         c = cur_r % CELLS;
         cyc++;
         while (m_act[c]) begin c = (c + 1) % CELLS; cyc++; end
         m_act[c] = 1; m_shown[c] = 1; m_num[c] = k;
      end
      cnt = 0;
      while (bus.oBusy === 1'b1 && cnt < 300) begin cnt++; tick(); end
      check({tag, ".loadcyc"}, cnt, cyc);
      m_phase = PH_SHOW;
      m_exp   = 1;
      check_all(tag);
   endtask

   task automatic start_game(input string tag, input int r);
      cur_r = r;
      bus.iRandNum = 8'(r);
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      m_level = 4; m_lives = 3; m_score = 0; m_phase = PH_BUSY;
      do_load(tag);
   endtask

   // 0 ignored, 1 correct, 2 level complete, 3 wrong with reload, 4 game over
   task automatic model_click(input int x, input int y, output int act);
      int i;
      act = 0;
      if ((m_phase == PH_SHOW || m_phase == PH_PLAY) && x < 3 && y < 3) begin
         i = y * 3 + x;
         if (m_act[i]) begin
            if (m_num[i] == m_exp) begin
               m_act[i] = 0; m_num[i] = 0; m_shown[i] = 0;
               if (m_exp == m_level) act = 2;
               else begin
                  act = 1;
                  if (m_phase == PH_SHOW) begin
                     for (int j = 0; j < CELLS; j++) m_shown[j] = 0;
                     m_phase = PH_PLAY;
                  end
               end
               m_exp++;
            end else begin
               m_lives--;
               act = (m_lives == 0) ? 4 : 3;
               if (act == 4) m_phase = PH_OVER;
            end
         end
      end
   endtask

   task automatic click(input int x, input int y, input string tag);
      int act;
      set_rand();
      bus.iBoxX = 3'(x);
      bus.iBoxY = 3'(y);
      bus.iClick = 1'b1;
      tick();
      bus.iClick = 1'b0;
      model_click(x, y, act);
      check({tag, ".ldone"}, bus.oLevelDone, act == 2);
      if (act == 3) begin
         m_phase = PH_BUSY;
         check_all({tag, ".wrong"});
         do_load({tag, ".reload"});
      end else if (act == 2) begin
         check({tag, ".doneboard"}, bus.oBoard, model_board());
         tick();
         m_score = (m_score >= 255) ? 255 : m_score + 1;
         if (m_level == CELLS) begin
            m_phase = PH_WIN;
            check_all({tag, ".win"});
         end else begin
            m_level++;
            m_phase = PH_BUSY;
            do_load({tag, ".next"});
         end
      end else begin
         check_all(tag);
      end
   endtask

   function automatic int find_exp();
      for (int i = 0; i < CELLS; i++) if (m_act[i] && m_num[i] == m_exp) return i;
      return 0;
   endfunction

   function automatic int find_wrong();
      for (int i = 0; i < CELLS; i++) if (m_act[i] && m_num[i] != m_exp) return i;
      return -1;
   endfunction

   function automatic int find_empty();
      for (int i = 0; i < CELLS; i++) if (!m_act[i]) return i;
      return 0;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, cnt, r;
      logic [63:0] plan_board;
      bus.iStart = 0; bus.iRandNum = 0; bus.iClick = 0; bus.iBoxX = 0; bus.iBoxY = 0;
      bw.iStart = 0;  bw.iRandNum = 0;  bw.iClick = 0;  bw.iBoxX = 0;  bw.iBoxY = 0;
      model_reset();
      #12;
      check_all("reset");
      check("reset.ldone", bus.oLevelDone, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      click(1, 1, "idle_click");

      // Zero PRNG: numbers 1..4 land in cells 0..3
      start_game("plan", 0);
      plan_board = '0;
      for (int i = 0; i < 4; i++) plan_board[i*CW +: CW] = 7'h60 + 7'(i + 1);
      check("plan.board_const", bus.oBoard, plan_board);
      click(0, 0, "plan.c1");
      click(1, 0, "plan.c2");
      click(2, 0, "plan.c3");
      click(0, 1, "plan.c4");
      check("plan.score1", bus.oScore, 8'd1);
      check("plan.level5", bus.oLevel, 5'd5);

      // Ignored clicks: empty cell, off-board column, already cleared cell
      idx = find_empty();
      click(idx % 3, idx / 3, "ign.empty");
      click(3, 0, "ign.xoob");
      click(1, 3, "ign.yoob");
      idx = find_exp();
      click(idx % 3, idx / 3, "ign.first");
      click(idx % 3, idx / 3, "ign.cleared");

      // Lose all lives via wrong clicks in PLAY
      for (int n = 0; n < 3; n++) begin
         if (m_phase == PH_SHOW) begin
            idx = find_exp();
            click(idx % 3, idx / 3, "lives.correct");
         end
         idx = find_wrong();
         if (idx < 0) idx = find_exp();
         click(idx % 3, idx / 3, "lives.wrong");
      end
      check("lives.over", bus.oGameOver, 1'b1);
      check("lives.zero", bus.oLives, 3'd0);
      click(0, 0, "over.click");
      click(2, 2, "over.click2");

      // Restart mid-LOAD
      bus.iRandNum = 8'd77;
      bus.iStart = 1'b1; tick(); bus.iStart = 1'b0;
      tick(); tick(); tick();
      check("midload.busy", bus.oBusy, 1'b1);
      start_game("midload", 200);

      // Start and click together: click must be dropped
      cur_r = 31;
      bus.iRandNum = 8'd31;
      idx = find_exp();
      bus.iBoxX = 3'(idx % 3); bus.iBoxY = 3'(idx / 3);
      bus.iStart = 1'b1; bus.iClick = 1'b1;
      tick();
      bus.iStart = 1'b0; bus.iClick = 1'b0;
      m_level = 4; m_lives = 3; m_score = 0; m_phase = PH_BUSY;
      check_all("simul");
      do_load("simul.load");

      // Randomized play
      for (int n = 0; n < 250; n++) begin
         if (m_phase == PH_OVER || m_phase == PH_WIN) begin
            click($urandom_range(0, 3), $urandom_range(0, 3), "rnd.hold");
            start_game("rnd.restart", $urandom_range(0, 255));
         end else begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
               idx = find_exp();
               click(idx % 3, idx / 3, "rnd.correct");
            end else if (r < 85) begin
               idx = find_wrong();
               if (idx < 0) idx = find_exp();
               click(idx % 3, idx / 3, "rnd.wrong");
            end else begin
               click($urandom_range(0, 3), $urandom_range(0, 3), "rnd.any");
            end
         end
      end

      // Asynchronous reset in PLAY
      start_game("rst.start", 5);
      idx = find_exp();
      click(idx % 3, idx / 3, "rst.toplay");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst.async");
      check("rst.ldone", bus.oLevelDone, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      click(idx % 3, idx / 3, "rst.idleclick");

      // Top level from the start: winning completes the game
      bw.iRandNum = 8'd0;
      bw.iStart = 1'b1; tick(); bw.iStart = 1'b0;
      cnt = 0;
      while (bw.oBusy === 1'b1 && cnt < 300) begin cnt++; tick(); end
      check("win.loadcyc", cnt, 1 + 45);
      plan_board = '0;
      for (int i = 0; i < CELLS; i++) plan_board[i*CW +: CW] = 7'h60 + 7'(i + 1);
      check("win.board", bw.oBoard, plan_board);
      for (int i = 0; i < CELLS; i++) begin
         bw.iBoxX = 3'(i % 3); bw.iBoxY = 3'(i / 3); bw.iClick = 1'b1;
         tick();
         bw.iClick = 1'b0;
      end
      check("win.ldone", bw.oLevelDone, 1'b1);
      check("win.emptyboard", bw.oBoard, 64'd0);
      tick();
      check("win.score", bw.oScore, 8'd1);
      check("win.flag", bw.oWin, 1'b1);
      check("win.level", bw.oLevel, 5'd9);
      check("win.busy", bw.oBusy, 1'b0);
      check("win.ldone_off", bw.oLevelDone, 1'b0);
      bw.iBoxX = 0; bw.iBoxY = 0; bw.iClick = 1'b1;
      tick();
      bw.iClick = 1'b0;
      tick();
      check("win.hold", bw.oWin, 1'b1);
      check("win.holdscore", bw.oScore, 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/chimp_board_engine.md
# chimp_board_engine

Parametrised chimp-test game engine for a ROWS×COLS board. It places the numbers 1..level in random distinct cells and shows them until the first correct click, then hides the rest. It scores in-order clicks, tracks lives, and advances levels. It sits between the prng/chimpMouseClick front end and the VGA board renderer, and replaces the fixed 3×3 control/data path pair with one generalised block.

## Interface
- ROWS, 3, board rows (2..8)
- COLS, 3, board columns (2..8)
- NUM_W, 5, width of a cell number; must hold ROWS*COLS
- START_LEVEL, 4, numbers placed on the first level (1..ROWS*COLS)
- LIVES, 3, wrong clicks allowed before game over (1..7)
- RAND_W, 8, width of random input
- clk  in  1  system clock
- iResetN  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle pulse: start/restart the game
- iRandNum  in  RAND_W  free-running PRNG value
- iClick  in  1  one-cycle pulse: mouse click on box (iBoxX, iBoxY)
- iBoxX  in  3  clicked column
- iBoxY  in  3  clicked row
- oBoard  out  ROWS*COLS*(NUM_W+2)  cell i at bits [i*(NUM_W+2) +: NUM_W+2] = {active, shown, num}; i = y*COLS+x
- oLevel  out  NUM_W  current level (numbers on board)
- oLives  out  3  remaining lives
- oScore  out  8  levels completed, saturating at 255
- oLevelDone  out  1  one-cycle pulse on level completion
- oGameOver  out  1  high in OVER
- oWin  out  1  high in WIN
- oBusy  out  1  high in CLEAR or LOAD

## Operation
- States: IDLE, CLEAR, LOAD, SHOW, PLAY, DONE, OVER, WIN.
- Reset: state IDLE, oBoard all 0, oLevel=START_LEVEL, oLives=LIVES, oScore=0, all flags 0.
- IDLE: waits for iStart.
- iStart in any state, including mid-LOAD: oLevel=START_LEVEL, oLives=LIVES, oScore=0, next state CLEAR.
- CLEAR: 1 cycle. All cells := 0; placement counter k := 1; next state LOAD.
- LOAD (places number k):
  - Candidate c = iRandNum mod CELLS on the first cycle for k. On later cycles for the same k, c = probe register q.
  - If cell c is inactive, write {1,1,k}. If k==oLevel, go to SHOW; else k++.
  - If cell c is occupied, q := (c+1) wrapping to 0 at CELLS.
  - Each number takes at most CELLS cycles.
- Expected-number register e := 1 on entry to SHOW.
- Click handling, SHOW/PLAY only:
  - Ignored if iBoxX>=COLS, iBoxY>=ROWS, or the cell is inactive (empty or already cleared).
  - Correct (num==e): that cell := 0; e++. If it was e==1 in SHOW, clear shown on every cell and go to PLAY. If e==oLevel, go to DONE.
  - Wrong (active, num!=e): oLives--. If the new value is 0, go to OVER; else go to CLEAR at the same level.
- DONE: 1 cycle; oLevelDone=1; oScore++ (saturating). If oLevel==CELLS, go to WIN; else oLevel++ and go to CLEAR.
- Clicks in IDLE/CLEAR/LOAD/DONE/OVER/WIN are ignored.
- OVER and WIN hold the board until iStart.
- Level 1: a correct click on "1" in SHOW goes directly to DONE.

## Timing
- All outputs are registered. A click accepted at edge N is reflected in oBoard/oLives/state after edge N.
- Load latency from iStart: 1 (CLEAR) + Σ cycles per number. Minimum 1+level cycles with no collisions.
- Simultaneous iStart and iClick: iStart wins; the click is dropped.
- Reset deasserted asynchronously is synchronised externally. The block itself requires no reset release alignment.

## Test plan
- ROWS=COLS=3, iRandNum held 0, pulse iStart -> CLEAR 1 cycle. LOAD places 1,2,3,4 in cells 0..3 in 1+2+3+4=10 cycles, oBusy high 11 cycles. Then SHOW with oBoard cells 0..3 = {1,1,1..4}, cells 4..8 = 0.
- From that board, click (0,0) -> cell0 cleared, cells 1..3 shown=0, PLAY. Clicks (1,0),(2,0),(0,1) -> oLevelDone pulses once, oScore=1, oLevel=5, reload starts.
- At level 4 in PLAY with e=2, click cell holding 3 -> oLives 3→2, board reloaded at level 4. Repeat twice -> oLives=0, oGameOver=1, further clicks change nothing.
- Clicks on empty cell, on already-cleared cell, and at iBoxX=3 -> no state, board or lives change.
- START_LEVEL=9 on 3×3, complete level -> oScore=1, oWin=1, no further level.
- iStart asserted mid-LOAD, and iResetN pulsed low mid-PLAY -> respectively restart from CLEAR with oLevel=START_LEVEL, and immediate all-zero outputs with state IDLE.
